// File: rtl/afu_dfh_walker.sv
// Avalon-MM read master that walks a DFH chain from word 0, latching the
// first node's AFU ID and counting the headers visited.
module afu_dfh_walker #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned MAX_FEATURES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            error,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [63:0]           avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic [63:0]           afu_id_l,
    output logic [63:0]           afu_id_h,
    output logic [3:0]            feature_count,
    output logic [ADDR_WIDTH-1:0] last_hdr_addr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    // Sum width wide enough that base + 21-bit step never wraps.
    localparam int unsigned SW = ((ADDR_WIDTH > 21) ? ADDR_WIDTH : 21) + 1;
    localparam logic [SW-1:0] ADDR_LIMIT = (SW'(1) << ADDR_WIDTH) - SW'(3);

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
    localparam logic [2:0] ERR_TOO_LONG = 3'd2;
    localparam logic [2:0] ERR_ADDR_OVF = 3'd3;
    localparam logic [2:0] ERR_NOT_AFU  = 3'd4;

    typedef enum logic [2:0] {
        IDLE, RD_HDR, WAIT_HDR, RD_IDL, WAIT_IDL, RD_IDH, WAIT_IDH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  hdr_eol_q, hdr_eol_d;
    logic [20:0]           hdr_step_q, hdr_step_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2:0]            error_q, error_d;
    logic [63:0]           id_l_q, id_l_d;
    logic [63:0]           id_h_q, id_h_d;
    logic [3:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic                  read_q, read_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  fin;
    logic [2:0]            fin_err;
    logic                  do_eval;
    logic                  ev_eol;
    logic [20:0]           ev_step;
    logic [3:0]            ev_cnt;
    logic [SW-1:0]         next_base;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            hdr_eol_q  <= 1'b0;
            hdr_step_q <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= ERR_OK;
            id_l_q     <= '0;
            id_h_q     <= '0;
            count_q    <= '0;
            last_q     <= '0;
            read_q     <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            hdr_eol_q  <= hdr_eol_d;
            hdr_step_q <= hdr_step_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            id_l_q     <= id_l_d;
            id_h_q     <= id_h_d;
            count_q    <= count_d;
            last_q     <= last_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state: issue reads, capture responses, time out, evaluate next pointer.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        hdr_eol_d  = hdr_eol_q;
        hdr_step_d = hdr_step_q;
        tmo_d      = tmo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        id_l_d     = id_l_q;
        id_h_d     = id_h_q;
        count_d    = count_q;
        last_d     = last_q;
        read_d     = read_q;
        addr_d     = addr_q;
        fin        = 1'b0;
        fin_err    = ERR_OK;
        do_eval    = 1'b0;
        ev_eol     = hdr_eol_q;
        ev_step    = hdr_step_q;
        ev_cnt     = count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = ERR_OK;
                    count_d = '0;
                    id_l_d  = '0;
                    id_h_d  = '0;
                    last_d  = '0;
                    base_d  = '0;
                    busy_d  = 1'b1;
                    read_d  = 1'b1;
                    addr_d  = '0;
                    state_d = RD_HDR;
                end
            end
            RD_HDR, RD_IDL, RD_IDH: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = (state_q == RD_HDR) ? WAIT_HDR :
                              (state_q == RD_IDL) ? WAIT_IDL : WAIT_IDH;
                end
            end
            WAIT_HDR, WAIT_IDL, WAIT_IDH: begin
                if (avm_readdatavalid) begin
                    if (state_q == WAIT_HDR) begin
                        count_d    = count_q + 4'd1;
                        last_d     = base_q;
                        hdr_eol_d  = avm_readdata[40];
                        hdr_step_d = avm_readdata[39:19];
                        if (count_q == 4'd0) begin
                            if (avm_readdata[63:60] != 4'h1) begin
                                fin     = 1'b1;
                                fin_err = ERR_NOT_AFU;
                            end else begin
                                read_d  = 1'b1;
                                addr_d  = base_q + ADDR_WIDTH'(1);
                                state_d = RD_IDL;
                            end
                        end else begin
                            do_eval = 1'b1;
                            ev_eol  = avm_readdata[40];
                            ev_step = avm_readdata[39:19];
                            ev_cnt  = count_q + 4'd1;
                        end
                    end else if (state_q == WAIT_IDL) begin
                        id_l_d  = avm_readdata;
                        read_d  = 1'b1;
                        addr_d  = base_q + ADDR_WIDTH'(2);
                        state_d = RD_IDH;
                    end else begin
                        id_h_d  = avm_readdata;
                        do_eval = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fin     = 1'b1;
                    fin_err = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        next_base = SW'(base_q) + SW'(ev_step);

        if (do_eval) begin
            if (ev_eol || (ev_step == '0)) begin
                fin     = 1'b1;
                fin_err = ERR_OK;
            end else if (next_base > ADDR_LIMIT) begin
                fin     = 1'b1;
                fin_err = ERR_ADDR_OVF;
            end else if (ev_cnt == 4'(MAX_FEATURES)) begin
                fin     = 1'b1;
                fin_err = ERR_TOO_LONG;
            end else begin
                base_d  = ADDR_WIDTH'(next_base);
                read_d  = 1'b1;
                addr_d  = ADDR_WIDTH'(next_base);
                state_d = RD_HDR;
            end
        end

        if (fin) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            read_d  = 1'b0;
            error_d = fin_err;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign afu_id_l      = id_l_q;
    assign afu_id_h      = id_h_q;
    assign feature_count = count_q;
    assign last_hdr_addr = last_q;

endmodule

// File: tb/tb_afu_dfh_walker.sv
// Bench for afu_dfh_walker: Avalon slave model over a sparse memory, a
// reference walk that predicts reads and results, and a negedge monitor.
module tb_afu_dfh_walker;

    localparam int unsigned AW   = 16;
    localparam int unsigned MAXF = 8;
    localparam int unsigned TMO  = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [2:0]    error;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_waitrequest;
    logic [63:0]   avm_readdata;
    logic          avm_readdatavalid;
    logic [63:0]   afu_id_l;
    logic [63:0]   afu_id_h;
    logic [3:0]    feature_count;
    logic [AW-1:0] last_hdr_addr;

    afu_dfh_walker #(.ADDR_WIDTH(AW), .MAX_FEATURES(MAXF), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .afu_id_l(afu_id_l), .afu_id_h(afu_id_h), .feature_count(feature_count),
        .last_hdr_addr(last_hdr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    err;
        logic [3:0]    cnt;
        logic [63:0]   idl;
        logic [63:0]   idh;
        logic [AW-1:0] last;
        bit            tmo;
    } res_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0]  mem [int unsigned];
    res_t         exp_res[$];
    int unsigned  exp_addr[$];

    int stall_cfg = 0;
    int lat_min   = 0;
    int lat_max   = 0;
    int drop_addr = -1;

    int done_cnt = 0;
    int acc_cnt  = 0;
    int acc_cyc  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rd(input int unsigned a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    // Reference walk: plain loop over the chain rules, pushing reads and result.
    function automatic void model();
        res_t        r;
        int unsigned base;
        int unsigned step;
        logic [63:0] h;
        r = '{err: 3'd0, cnt: 4'd0, idl: 64'd0, idh: 64'd0, last: '0, tmo: 1'b0};
        base = 0;
        for (int it = 0; it < 64; it++) begin
            exp_addr.push_back(base);
            if (int'(base) == drop_addr) begin r.err = 3'd1; r.tmo = 1'b1; break; end
            h = rd(base);
            r.cnt = r.cnt + 4'd1;
            r.last = AW'(base);
            if (r.cnt == 4'd1) begin
                if (h[63:60] != 4'h1) begin r.err = 3'd4; break; end
                exp_addr.push_back(base + 1);
                if (int'(base + 1) == drop_addr) begin r.err = 3'd1; r.tmo = 1'b1; break; end
                r.idl = rd(base + 1);
                exp_addr.push_back(base + 2);
                if (int'(base + 2) == drop_addr) begin r.err = 3'd1; r.tmo = 1'b1; break; end
                r.idh = rd(base + 2);
            end
            step = 32'(h[39:16]) >> 3;
            if (h[40] || step == 0) break;
            if (base + step > (32'd1 << AW) - 3) begin r.err = 3'd3; break; end
            if (int'(r.cnt) == int'(MAXF)) begin r.err = 3'd2; break; end
            base = base + step;
        end
        exp_res.push_back(r);
    endfunction

    // Cycle counter (index of the most recent rising edge).
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Avalon slave: configurable stalls, latency, and an address that never answers.
    initial begin
        bit          pend;
        int          pend_dly;
        int unsigned pend_addr;
        int          stall_n;
        pend = 0; pend_dly = 0; pend_addr = 0; stall_n = 0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = 64'h0;
        forever begin
            @(posedge clk);
            #1;
            avm_readdatavalid = 1'b0;
            if (pend) begin
                if (pend_dly == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = rd(pend_addr);
                    pend = 0;
                end else begin
                    pend_dly--;
                end
            end
            if (avm_read === 1'b1) begin
                if (stall_n < stall_cfg) begin
                    avm_waitrequest = 1'b1;
                    stall_n++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_n = 0;
                    if (int'(avm_address) != drop_addr) begin
                        pend = 1;
                        pend_addr = int'(avm_address);
                        pend_dly = $urandom_range(lat_max, lat_min);
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    // Monitor: checks read addresses on accept, bus stability under stall, results on done.
    initial begin
        bit            prev_stall;
        logic [AW-1:0] prev_addr;
        res_t          r;
        prev_stall = 0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("read_hold", 64'(avm_read), 64'd1);
                    chk("addr_hold", 64'(avm_address), 64'(prev_addr));
                end
                prev_stall = avm_read && avm_waitrequest;
                prev_addr = avm_address;
                if (avm_read && !avm_waitrequest) begin
                    acc_cyc = cyc + 1;
                    acc_cnt++;
                    if (exp_addr.size() == 0) chk("unexpected_read", 64'(avm_address), 64'hFFFF_FFFF);
                    else chk("read_addr", 64'(avm_address), 64'(exp_addr.pop_front()));
                end
                if (done) begin
                    done_cnt++;
                    if (exp_res.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        r = exp_res.pop_front();
                        chk("error", 64'(error), 64'(r.err));
                        chk("feature_count", 64'(feature_count), 64'(r.cnt));
                        chk("afu_id_l", afu_id_l, r.idl);
                        chk("afu_id_h", afu_id_h, r.idh);
                        chk("last_hdr_addr", 64'(last_hdr_addr), 64'(r.last));
                        chk("busy_at_done", 64'(busy), 64'd0);
                        chk("reads_consumed", 64'(exp_addr.size()), 64'd0);
                        if (r.tmo) chk("timeout_latency", 64'(cyc - acc_cyc), 64'(TMO));
                    end
                end
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_read"}, 64'(avm_read), 64'd0);
        chk({tag, "_addr"}, 64'(avm_address), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_count"}, 64'(feature_count), 64'd0);
        chk({tag, "_idl"}, afu_id_l, 64'd0);
        chk({tag, "_idh"}, afu_id_h, 64'd0);
        chk({tag, "_last"}, 64'(last_hdr_addr), 64'd0);
    endtask

    task automatic run_walk(input bit poke);
        int d0;
        model();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 5000 && done_cnt == d0; i++) begin
            @(negedge clk);
            start = (poke && i == 3 && busy) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        if (done_cnt == d0) chk("walk_finished", 64'd0, 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    function automatic void single_afu();
        mem.delete();
        mem[0] = 64'h1000_0100_0000_0000;
        mem[1] = 64'h9081_F88B_8F65_5CAA;
        mem[2] = 64'h331D_B30C_9885_41EA;
    endfunction

    function automatic void gen_random();
        logic [63:0] h;
        mem.delete();
        for (int unsigned a = 0; a < 48; a++) begin
            h = {$urandom, $urandom};
            if (a == 0 && $urandom_range(9, 0) != 0) h[63:60] = 4'h1;
            h[40] = ($urandom_range(3, 0) == 0);
            case ($urandom_range(9, 0))
                0:       h[39:16] = 24'h0;
                1:       h[39:16] = 24'($urandom);
                default: h[39:16] = 24'($urandom_range(6, 1) * 8 + $urandom_range(7, 0));
            endcase
            mem[a] = h;
        end
        drop_addr = ($urandom_range(7, 0) == 0) ? int'($urandom_range(10, 0)) : -1;
        stall_cfg = $urandom_range(3, 0);
        lat_min = 0;
        lat_max = $urandom_range(4, 0);
    endfunction

    initial begin
        int a0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;

        // Single AFU node.
        single_afu();
        lat_min = 0; lat_max = 2;
        run_walk(1'b1);

        // Two-node chain: reads 0,1,2,8.
        mem.delete();
        mem[0] = 64'h1000_0000_0040_0000;
        mem[1] = 64'hA5A5_0000_1111_2222;
        mem[2] = 64'h5A5A_3333_4444_5555;
        mem[8] = 64'h3000_0100_0000_0000;
        run_walk(1'b0);

        // Stalled slave.
        single_afu();
        stall_cfg = 5;
        run_walk(1'b0);
        stall_cfg = 0;

        // ID_H never answered.
        single_afu();
        drop_addr = 2;
        run_walk(1'b0);
        drop_addr = -1;

        // Chain longer than MAX_FEATURES.
        mem.delete();
        for (int unsigned a = 0; a < 16; a++) mem[a] = 64'h1000_0000_0008_0000;
        run_walk(1'b0);

        // First node not an AFU.
        mem.delete();
        mem[0] = 64'h3000_0100_0000_0000;
        run_walk(1'b0);

        // Address boundary: last legal header base, then one past.
        mem.delete();
        mem[0] = {4'h1, 19'h0, 1'b0, 24'(65533 * 8), 16'h0};
        mem[65533] = 64'h2000_0100_0000_0000;
        run_walk(1'b0);
        mem[0] = {4'h1, 19'h0, 1'b0, 24'(65534 * 8), 16'h0};
        run_walk(1'b0);
        mem[0] = 64'h1000_00FF_FFFF_0000;
        run_walk(1'b0);

        // Reset while waiting on ID_L, with its response arriving late.
        single_afu();
        lat_min = 12; lat_max = 12;
        model();
        a0 = acc_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && acc_cnt < a0 + 2; i++) @(negedge clk);
        if (acc_cnt < a0 + 2) chk("idl_accept_seen", 64'(acc_cnt - a0), 64'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("midreset");
        reset = 1'b0;
        exp_addr.delete();
        exp_res.delete();
        repeat (20) @(negedge clk);
        check_idle_zero("stale");
        lat_min = 0; lat_max = 2;
        run_walk(1'b0);

        // Randomized chains.
        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_walk(t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
